fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 100 ++++++++++
 tb/tb_fetch_unit.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential PC generation, one-cycle-latency imem interface,
// a one-entry skid buffer behind a registered decode-facing output, and redirect handling.
module fetch_unit #(
  parameter int          ADDR_WIDTH = 11,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [31:0]           imem_dout,
  input  logic                  redirect_valid,
  input  logic [31:0]           redirect_pc,
  input  logic                  id_ready,
  output logic                  instr_valid,
  output logic [31:0]           instr,
  output logic [31:0]           instr_pc
);

  logic [31:0] pc_q;
  logic        rsp_valid;
  logic [31:0] rsp_pc;
  logic        skid_valid;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        issue;
  logic        load;

  // Issue/load decisions and the memory address for this cycle
  always_comb begin
    issue = !skid_valid && (!out_valid || id_ready);
    load  = !out_valid || id_ready;
    if (reset) begin
      imem_addr = RESET_PC[ADDR_WIDTH+1:2];
    end else if (redirect_valid) begin
      imem_addr = redirect_pc[ADDR_WIDTH+1:2];
    end else begin
      imem_addr = pc_q[ADDR_WIDTH+1:2];
    end
  end

  // PC, in-flight tracking, skid buffer and output register
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      rsp_valid  <= 1'b0;
      rsp_pc     <= 32'h0000_0000;
      skid_valid <= 1'b0;
      skid_instr <= 32'h0000_0000;
      skid_pc    <= 32'h0000_0000;
      out_valid  <= 1'b0;
      out_instr  <= 32'h0000_0000;
      out_pc     <= 32'h0000_0000;
    end else if (redirect_valid) begin
      // Everything older than the redirect target is squashed, even a stalled output.
      pc_q       <= redirect_pc + 32'd4;
      rsp_valid  <= 1'b1;
      rsp_pc     <= redirect_pc;
      skid_valid <= 1'b0;
      out_valid  <= 1'b0;
    end else begin
      if (issue) begin
        pc_q      <= pc_q + 32'd4;
        rsp_valid <= 1'b1;
        rsp_pc    <= pc_q;
      end else begin
        rsp_valid <= 1'b0;
      end

      if (load) begin
        if (skid_valid) begin
          out_valid  <= 1'b1;
          out_instr  <= skid_instr;
          out_pc     <= skid_pc;
          skid_valid <= 1'b0;
        end else if (rsp_valid) begin
          out_valid <= 1'b1;
          out_instr <= imem_dout;
          out_pc    <= rsp_pc;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (rsp_valid) begin
        // Issue is blocked while the skid is full, so it is always empty here.
        skid_valid <= 1'b1;
        skid_instr <= imem_dout;
        skid_pc    <= rsp_pc;
      end else begin
        skid_valid <= skid_valid;
      end
    end
  end

  assign instr_valid = out_valid;
  assign instr       = out_instr;
  assign instr_pc    = out_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory holds mem[k]=k, a scoreboard queue of expected
// PCs is checked on every decode handshake, plus cycle-exact checks per scenario.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset, redirect_valid, id_ready;
  logic [31:0] redirect_pc;
  logic [10:0] imem_addr;
  logic [31:0] imem_dout;
  logic        instr_valid;
  logic [31:0] instr, instr_pc;

  logic        reset_w, id_ready_w, redirect_valid_w;
  logic [31:0] redirect_pc_w;
  logic [10:0] imem_addr_w;
  logic [31:0] imem_dout_w;
  logic        instr_valid_w;
  logic [31:0] instr_w, instr_pc_w;

  int total = 0;
  int bad = 0;
  logic [31:0] q[$];
  logic        mon_en = 1'b0;
  logic        stall_prev = 1'b0;
  logic [31:0] stall_pc, stall_instr, exp_pc, exp_ins;

  always #5 clk = ~clk;

  fetch_unit #(.ADDR_WIDTH(11), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_dout(imem_dout),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .id_ready(id_ready),
    .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc));

  fetch_unit #(.ADDR_WIDTH(11), .RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clk(clk), .reset(reset_w), .imem_addr(imem_addr_w), .imem_dout(imem_dout_w),
    .redirect_valid(redirect_valid_w), .redirect_pc(redirect_pc_w), .id_ready(id_ready_w),
    .instr_valid(instr_valid_w), .instr(instr_w), .instr_pc(instr_pc_w));

  // Synchronous-read instruction memories with mem[k] = k
  always @(posedge clk) begin
    imem_dout   <= {21'h0, imem_addr};
    imem_dout_w <= {21'h0, imem_addr_w};
  end

  // Scoreboard: every accepted instruction must be the next expected PC; stalls must hold
  always @(negedge clk) begin
    if (mon_en && stall_prev) begin
      total++;
      if (instr_valid !== 1'b1 || instr_pc !== stall_pc || instr !== stall_instr) begin
        bad++;
        $display("FAIL stall_stable got v=%b pc=%h ins=%h want pc=%h ins=%h",
                 instr_valid, instr_pc, instr, stall_pc, stall_instr);
      end
    end
    if (mon_en && instr_valid === 1'b1 && id_ready === 1'b1) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL extra_instr got pc=%h want none", instr_pc);
      end else begin
        exp_pc  = q.pop_front();
        exp_ins = {21'h0, exp_pc[12:2]};
        if (instr_pc !== exp_pc || instr !== exp_ins) begin
          bad++;
          $display("FAIL seq got pc=%h ins=%h want pc=%h ins=%h", instr_pc, instr, exp_pc, exp_ins);
        end
      end
    end
    stall_prev  = mon_en && instr_valid === 1'b1 && id_ready === 1'b0 && !redirect_valid && !reset;
    stall_pc    = instr_pc;
    stall_instr = instr;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic release_reset;
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'h0; id_ready = 1'b1;
    reset_w = 1'b1; redirect_valid_w = 1'b0; redirect_pc_w = 32'h0; id_ready_w = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    total++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0) begin
      bad++; $display("FAIL reset_out got v=%b ins=%h pc=%h want 0", instr_valid, instr, instr_pc);
    end
    total++;
    if (imem_addr !== 11'h000 || imem_addr_w !== 11'h7FE) begin
      bad++; $display("FAIL reset_addr got %h/%h want 000/7fe", imem_addr, imem_addr_w);
    end
  endtask

  task automatic test_stream;
    q.delete();
    for (int i = 0; i < 10; i++) q.push_back(32'(i * 4));
    release_reset();
    mon_en = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (instr_valid !== 1'b0 || imem_addr !== 11'(c)) begin
        bad++; $display("FAIL stream_fill c=%0d got v=%b addr=%h want 0/%h", c, instr_valid, imem_addr, c);
      end
      tick();
    end
    @(negedge clk);
    total++;
    if (instr_valid !== 1'b1) begin
      bad++; $display("FAIL stream_latency got v=%b want 1", instr_valid);
    end
    for (int i = 0; i < 40 && q.size() != 0; i++) tick();
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL stream_drain got left=%0d want 0", q.size());
    end
    mon_en = 1'b0;
  endtask

  task automatic test_stall;
    q.delete();
    for (int i = 0; i < 6; i++) q.push_back(32'(i * 4));
    release_reset();
    mon_en = 1'b1;
    repeat (4) tick();
    id_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h8 || instr !== 32'h2) begin
        bad++; $display("FAIL stall_hold c=%0d got v=%b pc=%h want pc=8", c, instr_valid, instr_pc);
      end
      if (c == 1) begin
        total++;
        if (dut.skid_valid !== 1'b1) begin
          bad++; $display("FAIL stall_skid got %b want 1", dut.skid_valid);
        end
      end
      tick();
    end
    id_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) tick();
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL stall_drain got left=%0d want 0", q.size());
    end
    mon_en = 1'b0;
  endtask

  task automatic test_redirect;
    q.delete();
    q.push_back(32'h0); q.push_back(32'h4);
    q.push_back(32'h40); q.push_back(32'h44); q.push_back(32'h48);
    release_reset();
    mon_en = 1'b1;
    repeat (3) tick();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    @(negedge clk);
    total++;
    if (imem_addr !== 11'h010) begin
      bad++; $display("FAIL redir_addr got %h want 010", imem_addr);
    end
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    total++;
    if (instr_valid !== 1'b0) begin
      bad++; $display("FAIL redir_bubble got v=%b want 0", instr_valid);
    end
    tick();
    @(negedge clk);
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h40) begin
      bad++; $display("FAIL redir_target got v=%b pc=%h want 1/40", instr_valid, instr_pc);
    end
    for (int i = 0; i < 40 && q.size() != 0; i++) tick();
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL redir_drain got left=%0d want 0", q.size());
    end
    mon_en = 1'b0;
  endtask

  task automatic test_redirect_stall;
    q.delete();
    q.push_back(32'h0); q.push_back(32'h4); q.push_back(32'h80); q.push_back(32'h84);
    release_reset();
    mon_en = 1'b1;
    repeat (4) tick();
    id_ready = 1'b0;
    tick();
    @(negedge clk);
    total++;
    if (dut.skid_valid !== 1'b1 || instr_pc !== 32'h8) begin
      bad++; $display("FAIL rs_full got skid=%b pc=%h want 1/8", dut.skid_valid, instr_pc);
    end
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h80;
    @(negedge clk);
    total++;
    if (imem_addr !== 11'h020) begin
      bad++; $display("FAIL rs_addr got %h want 020", imem_addr);
    end
    tick();
    redirect_valid = 1'b0;
    @(negedge clk);
    total++;
    if (instr_valid !== 1'b0) begin
      bad++; $display("FAIL rs_drop got v=%b pc=%h want 0", instr_valid, instr_pc);
    end
    tick();
    @(negedge clk);
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h80 || instr !== 32'h20) begin
      bad++; $display("FAIL rs_target got v=%b pc=%h want 1/80", instr_valid, instr_pc);
    end
    tick();
    id_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) tick();
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL rs_drain got left=%0d want 0", q.size());
    end
    mon_en = 1'b0;
  endtask

  task automatic test_reset_mid;
    release_reset();
    repeat (4) tick();
    id_ready = 1'b0;
    tick();
    @(negedge clk);
    total++;
    if (dut.skid_valid !== 1'b1 || instr_valid !== 1'b1) begin
      bad++; $display("FAIL rm_full got skid=%b v=%b want 1/1", dut.skid_valid, instr_valid);
    end
    tick();
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (imem_addr !== 11'h000) begin
      bad++; $display("FAIL rm_addr got %h want 000", imem_addr);
    end
    tick();
    @(negedge clk);
    total++;
    if (instr_valid !== 1'b0 || instr !== 32'h0 || instr_pc !== 32'h0 || dut.skid_valid !== 1'b0) begin
      bad++; $display("FAIL rm_clear got v=%b ins=%h pc=%h skid=%b want 0", instr_valid, instr, instr_pc, dut.skid_valid);
    end
    q.delete();
    q.push_back(32'h0); q.push_back(32'h4); q.push_back(32'h8);
    id_ready = 1'b1;
    tick();
    reset = 1'b0;
    mon_en = 1'b1;
    repeat (2) tick();
    @(negedge clk);
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin
      bad++; $display("FAIL rm_refetch got v=%b pc=%h want 1/0", instr_valid, instr_pc);
    end
    for (int i = 0; i < 40 && q.size() != 0; i++) tick();
    total++;
    if (q.size() != 0) begin
      bad++; $display("FAIL rm_drain got left=%0d want 0", q.size());
    end
    mon_en = 1'b0;
  endtask

  task automatic test_wrap;
    logic [10:0] want_addr [3];
    logic [31:0] want_pc [3];
    want_addr[0] = 11'h7FE; want_addr[1] = 11'h7FF; want_addr[2] = 11'h000;
    want_pc[0] = 32'hFFFF_FFF8; want_pc[1] = 32'hFFFF_FFFC; want_pc[2] = 32'h0000_0000;
    reset_w = 1'b1;
    tick();
    reset_w = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c < 3) begin
        total++;
        if (imem_addr_w !== want_addr[c]) begin
          bad++; $display("FAIL wrap_addr c=%0d got %h want %h", c, imem_addr_w, want_addr[c]);
        end
      end
      if (c >= 2) begin
        total++;
        if (instr_valid_w !== 1'b1 || instr_pc_w !== want_pc[c-2] || instr_w !== {21'h0, want_addr[c-2]}) begin
          bad++; $display("FAIL wrap_out c=%0d got v=%b pc=%h ins=%h want pc=%h", c, instr_valid_w, instr_pc_w, instr_w, want_pc[c-2]);
        end
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_stall();
    test_reset_mid();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
